// File: rtl/c17_bist_pkg.sv
// c17_bist_pkg
//   Shared types and constants for the c17 BIST controller and its MISR.
//   Contents:
//     state_e    controller FSM states
//     PAT_W      width of the exhaustive pattern / pattern index (5)
//     RESP_W     width of the CUT response (2)
//     SIG_W      width of the MISR signature (8)
//     CNT_W      width of the settle counter (holds 0..14)
//     MISR_POLY  feedback taps of the MISR (x^8+x^4+x^3+x^2+1)
//     LAST_PAT   index of the final pattern
//     misr_next  one MISR compaction step
package c17_bist_pkg;

    localparam int PAT_W  = 5;
    localparam int RESP_W = 2;
    localparam int SIG_W  = 8;
    localparam int CNT_W  = 4;

    localparam logic [SIG_W-1:0] MISR_POLY = 8'h1D;
    localparam logic [PAT_W-1:0] LAST_PAT  = 5'd31;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_APPLY,
        ST_CAPTURE,
        ST_CHECK,
        ST_DONE
    } state_e;

    // Shift left, fold the outgoing MSB back through the polynomial taps,
    // then XOR the response into the low bits.
    function automatic logic [SIG_W-1:0] misr_next(
        input logic [SIG_W-1:0]  sig,
        input logic [RESP_W-1:0] resp
    );
        logic [SIG_W-1:0] fb;
        fb = sig[SIG_W-1] ? MISR_POLY : '0;
        return {sig[SIG_W-2:0], 1'b0} ^ fb ^ {{(SIG_W-RESP_W){1'b0}}, resp};
    endfunction

endpackage

// File: rtl/c17_bist_if.sv
// c17_bist_if
//   Bundles the host handshake, status outputs and the CUT pattern/response
//   pair of the c17 BIST controller.
//   Signals:
//     start      host start request
//     abort      host abort request
//     cut_in     pattern driven to the c17 CUT (N1,N2,N3,N6,N7 from MSB)
//     cut_resp   CUT response (N22,N23 from MSB)
//     busy       run in progress
//     done       run finished, pass valid
//     pass       final signature matched the golden value
//     signature  current MISR contents
//     pat_idx    index of the pattern currently applied
//   Modports:
//     slave      the controller
//     master     the host side, which also carries the CUT response
interface c17_bist_if;
    import c17_bist_pkg::*;

    logic              start;
    logic              abort;
    logic [PAT_W-1:0]  cut_in;
    logic [RESP_W-1:0] cut_resp;
    logic              busy;
    logic              done;
    logic              pass;
    logic [SIG_W-1:0]  signature;
    logic [PAT_W-1:0]  pat_idx;

    modport slave (
        input  start, abort, cut_resp,
        output cut_in, busy, done, pass, signature, pat_idx
    );

    modport master (
        output start, abort, cut_resp,
        input  cut_in, busy, done, pass, signature, pat_idx
    );

endinterface

// File: rtl/c17_misr.sv
// c17_misr
//   8-bit multiple-input signature register compacting the 2-bit c17
//   response, one step per enabled clock.
//   Ports:
//     clk    clock, rising edge
//     rst_n  asynchronous active-low reset, clears the signature
//     clr    synchronous clear, wins over en
//     en     compact resp into the signature this cycle
//     resp   CUT response
//     sig    registered signature
module c17_misr
    import c17_bist_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              en,
    input  logic [RESP_W-1:0] resp,
    output logic [SIG_W-1:0]  sig
);

    logic [SIG_W-1:0] sig_q;
    logic [SIG_W-1:0] sig_d;

    always_comb begin
        sig_d = sig_q;
        if (clr) begin
            sig_d = '0;
        end else if (en) begin
            sig_d = misr_next(sig_q, resp);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_q <= '0;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig = sig_q;

endmodule

// File: rtl/c17_bist_ctrl.sv
// c17_bist_ctrl
//   BIST controller for the ISCAS-85 c17 circuit. Applies all 32 input
//   patterns in ascending order, holds each for SETTLE_CYC cycles, compacts
//   each response into an 8-bit MISR and compares the final signature with
//   GOLDEN.
//   Parameters:
//     SETTLE_CYC  cycles each pattern is held before capture (1..15)
//     GOLDEN      expected final signature
//   Ports:
//     clk    clock, rising edge
//     rst_n  asynchronous active-low reset
//     bus    c17_bist_if slave: start/abort in, status and CUT pattern out,
//            CUT response in
//   Every output is a register; no input reaches an output combinationally.
module c17_bist_ctrl
    import c17_bist_pkg::*;
#(
    parameter int unsigned      SETTLE_CYC = 1,
    parameter logic [SIG_W-1:0] GOLDEN     = 8'h00
) (
    input  logic      clk,
    input  logic      rst_n,
    c17_bist_if.slave bus
);

    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);

    state_e            state_q, state_d;
    logic [PAT_W-1:0]  pat_q,   pat_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic [PAT_W-1:0]  cut_q,   cut_d;
    logic              busy_q,  busy_d;
    logic              done_q,  done_d;
    logic              pass_q,  pass_d;
    // Low for the first edge after reset release so a start held across
    // reset is not acted on in that cycle.
    logic              armed_q;

    logic              misr_clr;
    logic              misr_en;
    logic [SIG_W-1:0]  sig;

    c17_misr u_misr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (misr_clr),
        .en    (misr_en),
        .resp  (bus.cut_resp),
        .sig   (sig)
    );

    always_comb begin
        state_d  = state_q;
        pat_d    = pat_q;
        cnt_d    = cnt_q;
        pass_d   = pass_q;
        misr_clr = 1'b0;
        misr_en  = 1'b0;

        // Abort outranks everything, including a simultaneous start. The
        // MISR is neither cleared nor updated, so the signature is kept.
        if (bus.abort) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            pass_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (bus.start && armed_q) begin
                        state_d  = ST_APPLY;
                        pat_d    = '0;
                        cnt_d    = '0;
                        pass_d   = 1'b0;
                        misr_clr = 1'b1;
                    end
                end
                ST_APPLY: begin
                    if (cnt_q == SETTLE_LAST) begin
                        state_d = ST_CAPTURE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_CAPTURE: begin
                    misr_en = 1'b1;
                    if (pat_q == LAST_PAT) begin
                        state_d = ST_CHECK;
                    end else begin
                        state_d = ST_APPLY;
                        pat_d   = pat_q + PAT_W'(1);
                    end
                end
                ST_CHECK: begin
                    pass_d  = (sig == GOLDEN);
                    state_d = ST_DONE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        // Status outputs are registered from the next state so they line
        // up with the state they describe.
        busy_d = (state_d == ST_APPLY) || (state_d == ST_CAPTURE) ||
                 (state_d == ST_CHECK);
        done_d = (state_d == ST_DONE);
        cut_d  = (state_d == ST_IDLE) ? '0 : pat_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            pat_q   <= '0;
            cnt_q   <= '0;
            cut_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            cnt_q   <= cnt_d;
            cut_q   <= cut_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            armed_q <= 1'b1;
        end
    end

    assign bus.cut_in    = cut_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.pass      = pass_q;
    assign bus.signature = sig;
    assign bus.pat_idx   = pat_q;

endmodule
